// File: rtl/jt12_slot_seq_if.sv
// Slot-sequencer bus: clock enable, frame resync, CPU write handshake and the
// slot timing outputs consumed by the phase/envelope/operator stages.
`timescale 1ns/1ps
interface jt12_slot_seq_if;
   logic       cen;
   logic       sync_in;
   logic       wr_req;
   logic [2:0] wr_ch;
   logic [1:0] wr_op;
   logic [4:0] slot;
   logic [2:0] cur_ch;
   logic [1:0] cur_op;
   logic [2:0] ch_p1;
   logic [2:0] ch_p2;
   logic       zero;
   logic       wr_ack;
   logic       wr_err;

   modport master (
      output cen, sync_in, wr_req, wr_ch, wr_op,
      input  slot, cur_ch, cur_op, ch_p1, ch_p2, zero, wr_ack, wr_err
   );

   modport slave (
      input  cen, sync_in, wr_req, wr_ch, wr_op,
      output slot, cur_ch, cur_op, ch_p1, ch_p2, zero, wr_ack, wr_err
   );
endinterface

// File: rtl/jt12_slot_seq.sv
// Walks the 24 FM operator slots per frame (channel fastest, operators S1,S3,S2,S4)
// and commits CPU writes in the slot owned by the target channel/operator.
`timescale 1ns/1ps
module jt12_slot_seq #(
   parameter int unsigned AHEAD1 = 1,
   parameter int unsigned AHEAD2 = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   jt12_slot_seq_if.slave    bus
);

   localparam logic [3:0] OFF1   = 4'(AHEAD1);
   localparam logic [3:0] OFF2   = 4'(AHEAD2);
   localparam logic [2:0] P1_RST = 3'(AHEAD1 % 6);
   localparam logic [2:0] P2_RST = 3'(AHEAD2 % 6);

   logic [1:0] r_grp;
   logic [2:0] r_ch;
   logic [2:0] r_p1;
   logic [2:0] r_p2;
   logic       r_zero;
   logic       r_ack;
   logic       r_err;

   logic [1:0] w_nxt_grp;
   logic [2:0] w_nxt_ch;
   logic       w_nxt_zero;
   logic [1:0] w_cur_op;
   logic       w_wr_bad;
   logic       w_wr_hit;

   // Offsets are at most 5, so a single conditional subtract keeps the result in 0..5.
   function automatic logic [2:0] add_mod6(input logic [2:0] a, input logic [3:0] off);
      logic [3:0] sum;
      sum = {1'b0, a} + off;
      return (sum >= 4'd6) ? 3'(sum - 4'd6) : 3'(sum);
   endfunction

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_nxt_grp = r_grp;
      w_nxt_ch  = r_ch;
      if (bus.sync_in) begin
         w_nxt_grp = 2'd0;
         w_nxt_ch  = 3'd0;
      end else if (r_ch == 3'd5) begin
         w_nxt_ch  = 3'd0;
         w_nxt_grp = r_grp + 2'd1;
      end else begin
         w_nxt_ch  = r_ch + 3'd1;
      end
   end

   assign w_nxt_zero = (w_nxt_grp == 2'd0) && (w_nxt_ch == 3'd0);

   always_comb begin
      w_cur_op = 2'd0;
      case (r_grp)
         2'd0: w_cur_op = 2'd0;
         2'd1: w_cur_op = 2'd2;
         2'd2: w_cur_op = 2'd1;
         2'd3: w_cur_op = 2'd3;
         default: w_cur_op = 2'd0;
      endcase
   end

   // Match uses the pre-advance slot, so a write still lands on a resync edge.
   assign w_wr_bad = (bus.wr_ch > 3'd5);
   assign w_wr_hit = bus.wr_req &&
                     (w_wr_bad || ((bus.wr_ch == r_ch) && (bus.wr_op == w_cur_op)));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grp  <= 2'd0;
         r_ch   <= 3'd0;
         r_p1   <= P1_RST;
         r_p2   <= P2_RST;
         r_zero <= 1'b1;
         r_ack  <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_ack <= bus.cen && w_wr_hit;
         r_err <= bus.cen && bus.wr_req && w_wr_bad;
         if (bus.cen) begin
            r_grp  <= w_nxt_grp;
            r_ch   <= w_nxt_ch;
            r_p1   <= add_mod6(w_nxt_ch, OFF1);
            r_p2   <= add_mod6(w_nxt_ch, OFF2);
            r_zero <= w_nxt_zero;
         end
      end
   end

   assign bus.slot   = 5'(r_grp) * 5'd6 + 5'(r_ch);
   assign bus.cur_ch = r_ch;
   assign bus.cur_op = w_cur_op;
   assign bus.ch_p1  = r_p1;
   assign bus.ch_p2  = r_p2;
   assign bus.zero   = r_zero;
   assign bus.wr_ack = r_ack;
   assign bus.wr_err = r_err;

endmodule

// File: doc/jt12_slot_seq.md
# jt12_slot_seq

Time-division slot sequencer for the FM operator pipeline. Walks the 24 operator slots (6 channels × 4 operators) once per sample frame and exports the current channel and operator indices plus registered mod-6 look-ahead channel indices for downstream pipeline stages. Also schedules CPU register writes so that each write commits exactly in the slot owned by its target channel/operator. It sits between the register interface and the phase/envelope/operator stages, as their single source of slot timing.

## Interface
- AHEAD1, default 1: channel look-ahead offset for ch_p1; legal 0..5.
- AHEAD2, default 2: channel look-ahead offset for ch_p2; legal 0..5.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cen  in  1  clock enable; the slot advances only on clk edges with cen=1.
- sync_in  in  1  frame resync; with cen=1, forces the next slot to 0.
- wr_req  in  1  write request; held with wr_ch/wr_op stable until wr_ack.
- wr_ch  in  3  target channel, 0..5 valid.
- wr_op  in  2  target operator, 0..3.
- slot  out  5  current slot, 0..23.
- cur_ch  out  3  current channel, 0..5.
- cur_op  out  2  current operator.
- ch_p1  out  3  (cur_ch+AHEAD1) mod 6.
- ch_p2  out  3  (cur_ch+AHEAD2) mod 6.
- zero  out  1  high throughout slot 0.
- wr_ack  out  1  one-clk pulse when the write is committed.
- wr_err  out  1  qualifies wr_ack: 1 when wr_ch was out of range (6 or 7).

## Operation
- State: group counter grp (0..3), channel counter ch (0..5). slot = grp*6 + ch. cur_ch = ch.
- Order: ch increments fastest; at ch=5, ch wraps to 0 and grp increments; at slot 23, both wrap to 0.
- cur_op = {0,2,1,3}[grp]: operator order is S1, S3, S2, S4.
- ch_p1 and ch_p2 are registered. They are updated on each advance from the next ch value, using mod-6 addition: compute the 4-bit sum, subtract 6 if the sum is ≥ 6. They never take the value 6 or 7.
- zero is registered and equals (next slot == 0).
- sync_in=1 with cen=1 loads grp=0 and ch=0, overriding the normal advance. sync_in with cen=0 is ignored.
- Write match: on an edge with cen=1, if wr_req=1, wr_ch ≤ 5, wr_ch == cur_ch and wr_op == cur_op, register wr_ack=1 and wr_err=0. The comparison uses the pre-advance state.
- Invalid channel: with cen=1 and wr_req=1, wr_ch ≥ 6 gives wr_ack=1 and wr_err=1 on the first cen edge. Nothing is committed.
- wr_ack and wr_err clear on every other clk edge, so each ack is exactly one clk wide.
- The requester drops wr_req in the cycle after wr_ack. If wr_req stays high with the same target, the next ack comes 24 cen edges later. No re-ack occurs earlier.
- The write match is evaluated on the same edge as sync_in, before the slot is reset.

## Timing
- Reset (rst_n=0, asynchronous) values:
  - Counters: grp=0, ch=0; slot=0, cur_ch=0, cur_op=0.
  - Look-ahead: ch_p1 = AHEAD1 mod 6, ch_p2 = AHEAD2 mod 6.
  - Flags: zero=1, wr_ack=0, wr_err=0.
- The first advance is on the first cen edge after rst_n deasserts.
- All outputs are registered, with zero combinational path from inputs.
- Frame period: 24 cen edges. zero is high for one cen period per frame.
- Write latency: 1 to 24 cen edges from wr_req assertion to wr_ack. wr_ack appears in the clk cycle after the matching cen edge.
- cen=0 for any duration: all state holds and no wr_ack is issued.
- Reset mid-frame or mid-request: state returns to the reset values and any pending ack is dropped. The requester must re-present its request.

## Test plan
- Reset, then 48 cen edges at cen=1 continuous:
  - slot runs 0..23 twice.
  - cur_op sequence is six 0s, six 2s, six 1s, six 3s.
  - zero is high at edges 0 and 24 only.
  - ch_p1/ch_p2 always equal (cur_ch+1)%6 and (cur_ch+2)%6.
- Build with AHEAD1=5, AHEAD2=0: at cur_ch=3, ch_p1=2 and ch_p2=3; no look-ahead value ever exceeds 5.
- cen=1 every third clk: slot advances once per 3 clk; wr_ack stays one clk wide.
- wr_req with wr_ch=4, wr_op=1 asserted at slot 0: wr_ack after the cen edge at slot 16, wr_err=0. Keep wr_req high with the same target: the second ack comes 24 cen edges later.
- wr_ch=7: wr_ack=1 and wr_err=1 after the first cen edge.
- sync_in pulse at slot 13 with cen=1: next slot=0 and zero=1. A matching write at slot 13 on the same edge is still acked.
- rst_n pulsed low at slot 9 with wr_req pending: outputs go to reset values immediately and no wr_ack is issued.
